// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder feeding a FIFO that streams into instruction memory at consecutive word addresses.
// Latency: accepted bundle appears on mem_we/mem_wdata the next cycle when the FIFO was empty; 1 word/cycle sustained.
// Backpressure: in_ready = FIFO not full; mem_* held stable while mem_ready=0. `INSTR_ENCODER_CHECK_EN enables immediate range checks.
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [15:0]           words_written,
    output logic                  err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FMT_R = 3'b000,
        FMT_I = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_U = 3'b100,
        FMT_J = 3'b101
    } fmt_e;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             legal;
    logic [31:0]      enc_word;
    logic             is_shift;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign mem_we    = !empty;
    assign pop       = mem_we && mem_ready;
    assign mem_wdata = empty ? 32'h0 : fifo_mem[rd_ptr[PTR_W-1:0]];
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef INSTR_ENCODER_CHECK_EN
    logic sx12;
    logic sx13;
    logic sx21;
    assign sx12 = (&imm[31:11]) || !(|imm[31:11]);
    assign sx13 = (&imm[31:12]) || !(|imm[31:12]);
    assign sx21 = (&imm[31:20]) || !(|imm[31:20]);
`endif

    always_comb begin
        enc_word = 32'h0;
        legal    = 1'b1;
        case (fmt)
            FMT_R: enc_word = {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, op};
            FMT_I: begin
                if (is_shift) begin
                    enc_word = {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, op};
`ifdef INSTR_ENCODER_CHECK_EN
                    legal = (imm[31:5] == 27'h0);
`endif
                end else begin
                    enc_word = {imm[11:0], rs1, funct3, rd, op};
`ifdef INSTR_ENCODER_CHECK_EN
                    legal = sx12;
`endif
                end
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = sx12;
`endif
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = sx13 && !imm[0];
`endif
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, op};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = (imm[11:0] == 12'h0);
`endif
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = sx21 && !imm[0];
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_addr      <= BASE_ADDR;
            words_written <= 16'h0;
            err           <= 1'b0;
        end else if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_addr      <= BASE_ADDR;
            words_written <= 16'h0;
            err           <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                mem_addr <= mem_addr + ADDR_WIDTH'(4);
                if (words_written != 16'hFFFF) begin
                    words_written <= words_written + 16'd1;
                end
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, streaming, backpressure, illegal drop, clear, async reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] words_written;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder #(.ADDR_WIDTH(32), .FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .words_written(words_written), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                         input logic f75, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
        in_valid = 1'b1;
        fmt = f; op = o; funct3 = f3; funct7_5 = f75;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        fmt = 3'b0; op = 7'b0; funct3 = 3'b0; funct7_5 = 1'b0;
        rd = 5'b0; rs1 = 5'b0; rs2 = 5'b0; imm = 32'h0;
        step(); step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_cmp++; if (words_written !== 16'h0) begin n_bad++; $display("FAIL reset_words got %0d want 0", words_written); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_r();
        mem_ready = 1'b1;
        drive(3'b000, 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0);
        step();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sub_mem_we got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL sub_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h402081B3) begin n_bad++; $display("FAIL sub_wdata got %h want 402081b3", mem_wdata); end
        step();
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL sub_drain got %b want 0", mem_we); end
        n_cmp++; if (words_written !== 16'd1) begin n_bad++; $display("FAIL sub_words got %0d want 1", words_written); end
        n_cmp++; if (mem_addr !== 32'h4) begin n_bad++; $display("FAIL sub_next_addr got %h want 4", mem_addr); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        mem_ready = 1'b1;
        drive(3'b001, 7'b0010011, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        step();
        drive(3'b101, 7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hFFF00293) begin
            n_bad++; $display("FAIL b2b_addi got we=%b addr=%h data=%h want 1/0/fff00293", mem_we, mem_addr, mem_wdata); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h008000EF) begin
            n_bad++; $display("FAIL b2b_jal got we=%b addr=%h data=%h want 1/4/008000ef", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if (mem_we !== 1'b0 || words_written !== 16'd2) begin
            n_bad++; $display("FAIL b2b_done got we=%b words=%0d want 0/2", mem_we, words_written); end
    endtask

    task automatic test_formats();
        logic [2:0]  t_fmt [4];
        logic [6:0]  t_op  [4];
        logic [2:0]  t_f3  [4];
        logic        t_f75 [4];
        logic [4:0]  t_rd  [4];
        logic [4:0]  t_rs1 [4];
        logic [4:0]  t_rs2 [4];
        logic [31:0] t_imm [4];
        logic [31:0] t_exp [4];
        // sw x5,-4(x2); lui x7,0x12345; srai x6,x6,3; bne x1,x2,-8
        t_fmt[0] = 3'b010; t_op[0] = 7'b0100011; t_f3[0] = 3'b010; t_f75[0] = 1'b0;
        t_rd[0] = 5'd0; t_rs1[0] = 5'd2; t_rs2[0] = 5'd5; t_imm[0] = 32'hFFFF_FFFC; t_exp[0] = 32'hFE512E23;
        t_fmt[1] = 3'b100; t_op[1] = 7'b0110111; t_f3[1] = 3'b000; t_f75[1] = 1'b0;
        t_rd[1] = 5'd7; t_rs1[1] = 5'd0; t_rs2[1] = 5'd0; t_imm[1] = 32'h1234_5000; t_exp[1] = 32'h123453B7;
        t_fmt[2] = 3'b001; t_op[2] = 7'b0010011; t_f3[2] = 3'b101; t_f75[2] = 1'b1;
        t_rd[2] = 5'd6; t_rs1[2] = 5'd6; t_rs2[2] = 5'd0; t_imm[2] = 32'd3; t_exp[2] = 32'h40335313;
        t_fmt[3] = 3'b011; t_op[3] = 7'b1100011; t_f3[3] = 3'b001; t_f75[3] = 1'b0;
        t_rd[3] = 5'd0; t_rs1[3] = 5'd1; t_rs2[3] = 5'd2; t_imm[3] = 32'hFFFF_FFF8; t_exp[3] = 32'hFE209CE3;
        do_clear();
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(t_fmt[k], t_op[k], t_f3[k], t_f75[k], t_rd[k], t_rs1[k], t_rs2[k], t_imm[k]);
            step();
            n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * k) || mem_wdata !== t_exp[k]) begin
                n_bad++; $display("FAIL fmt_vec%0d got we=%b addr=%h data=%h want 1/%h/%h",
                                  k, mem_we, mem_addr, mem_wdata, 32'(4 * k), t_exp[k]); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (words_written !== 16'd4) begin n_bad++; $display("FAIL fmt_words got %0d want 4", words_written); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = ((i + 1) << 7) | 32'h33;
        do_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 7'b0110011, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'h0);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready%0d got %b want 1", i, in_ready); end
            step();
        end
        drive(3'b000, 7'b0110011, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== w[0]) begin
                n_bad++; $display("FAIL bp_hold%0d got rdy=%b we=%b addr=%h data=%h want 0/1/0/%h",
                                  c, in_ready, mem_we, mem_addr, mem_wdata, w[0]); end
            step();
        end
        mem_ready = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
        for (int k = 1; k < 5; k++) begin
            if (k == 2) in_valid = 1'b0;
            n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * k) || mem_wdata !== w[k]) begin
                n_bad++; $display("FAIL bp_drain%0d got we=%b addr=%h data=%h want 1/%h/%h",
                                  k, mem_we, mem_addr, mem_wdata, 32'(4 * k), w[k]); end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b0 || words_written !== 16'd5 || mem_addr !== 32'd20) begin
            n_bad++; $display("FAIL bp_done got we=%b words=%0d addr=%h want 0/5/14", mem_we, words_written, mem_addr); end
    endtask

    task automatic test_illegal_and_clear();
        mem_ready = 1'b1;
        drive(3'b111, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b0 || err !== 1'b1) begin
            n_bad++; $display("FAIL ill_drop got we=%b err=%b want 0/1", mem_we, err); end
        step(); step();
        n_cmp++; if (err !== 1'b1 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL ill_sticky got err=%b we=%b want 1/0", err, mem_we); end
        do_clear();
        n_cmp++; if (err !== 1'b0 || mem_addr !== 32'h0 || words_written !== 16'd0) begin
            n_bad++; $display("FAIL clear got err=%b addr=%h words=%0d want 0/0/0", err, mem_addr, words_written); end
    endtask

    task automatic test_b_imm_check();
        do_clear();
        mem_ready = 1'b1;
        drive(3'b011, 7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
        step();
        in_valid = 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
        n_cmp++; if (mem_we !== 1'b0 || err !== 1'b1) begin
            n_bad++; $display("FAIL bimm_checked got we=%b err=%b want 0/1", mem_we, err); end
`else
        n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00208163 || err !== 1'b0) begin
            n_bad++; $display("FAIL bimm_trunc got we=%b data=%h err=%b want 1/00208163/0", mem_we, mem_wdata, err); end
`endif
        step();
        do_clear();
    endtask

    task automatic test_reset_midstream();
        do_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 7'b0110011, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'h0);
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got we=%b want 1", mem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0 || in_ready !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_async got we=%b data=%h rdy=%b addr=%h want 0/0/1/0",
                              mem_we, mem_wdata, in_ready, mem_addr); end
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++; if (mem_we !== 1'b0 || words_written !== 16'd0) begin
                n_bad++; $display("FAIL rstmid_stale%0d got we=%b words=%0d want 0/0", c, mem_we, words_written); end
        end
    endtask

    initial begin
        test_reset();
        test_single_r();
        test_back_to_back();
        test_formats();
        test_backpressure();
        test_illegal_and_clear();
        test_b_imm_check();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Field-level RV32I instruction encoder and instruction-memory writer, the inverse of the control-path decode. It accepts instruction fields (op, funct3, funct7_5, rd, rs1, rs2, immediate, format) over a valid/ready handshake and packs them into 32-bit instruction words. It buffers the words in a small FIFO and streams them into instruction memory at consecutive word addresses. It is used by the boot/program loader and by benches to program the core.

## Interface
- `ADDR_WIDTH`, 32, instruction-memory byte-address width
- `FIFO_DEPTH`, 4, encoded-word buffer depth (power of 2, ≥2)
- `BASE_ADDR`, 0, first write address after reset/clear (word aligned)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush: empties FIFO, address ← `BASE_ADDR`, count ← 0, err ← 0
- `in_valid`  in  1  field bundle valid
- `in_ready`  out  1  encoder can accept (= FIFO not full)
- `fmt`  in  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J; 110/111 illegal
- `op`  in  7  opcode field
- `funct3`  in  3  funct3 field
- `funct7_5`  in  1  instruction bit 30 (R-type, and I-type shifts)
- `rd`, `rs1`, `rs2`  in  5 each  register fields
- `imm`  in  32  immediate, full signed value (byte offset for B/J)
- `mem_we`  out  1  write request (= FIFO not empty)
- `mem_ready`  in  1  memory accepts write this cycle
- `mem_addr`  out  ADDR_WIDTH  write byte address
- `mem_wdata`  out  32  encoded word at FIFO head; 0 when empty
- `words_written`  out  16  accepted memory writes since reset/clear, saturating at 0xFFFF
- `err`  out  1  sticky: a bundle was dropped as illegal

## Operation
- Push when `in_valid && in_ready`; the word is encoded combinationally and written into the FIFO tail.
- Encodings, bits [31:0]:
  - R: {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}. When funct3 = 001 or 101 (shifts): {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Illegal `fmt`: the bundle is handshaken (consumed), not pushed, and `err` is set.
- Pop when `mem_we && mem_ready`. On pop, `mem_addr` += 4, wrapping modulo 2^ADDR_WIDTH, and `words_written` += 1.
- Push and pop in the same cycle are both performed and occupancy is unchanged. Because `in_ready` = !full, there is no push when full, even if a pop occurs that cycle.
- `clear` has priority over push and pop in the same cycle. Any push or pop that cycle is discarded.
- FIFO uses pointers one bit wider than needed; full/empty are derived from pointer MSB compare.

## Timing
- Reset values: `in_ready`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `words_written`=0, `err`=0, FIFO empty.
- Latency: bundle accepted at edge N → `mem_we`=1 with its word from cycle N+1 (when the FIFO was empty).
- Throughput: 1 word/cycle with `mem_ready` held high.
- `mem_we`, `mem_addr`, `mem_wdata` are held stable while `mem_ready`=0.
- Reset asserted mid-stream: all contents are lost immediately (async); outputs return to reset values.
- `in_ready` rises the cycle after a pop from full.

## Configuration
- `INSTR_ENCODER_CHECK_EN` defined: immediate range checks are applied. A bundle fails if any of these hold:
  - I/S imm is not a 12-bit sign extension.
  - I-shift imm is not within 0..31.
  - B imm is not a 13-bit sign extension or imm[0]≠0.
  - J imm is not a 21-bit sign extension or imm[0]≠0.
  - U imm[11:0]≠0.
  - A failing bundle is consumed, dropped, and sets `err`.
- Not defined: no range checks; out-of-range immediate bits are silently truncated. Only illegal `fmt` sets `err`.

## Test plan
- Reset, then push R-type op=0110011, funct3=000, funct7_5=1, rd=3, rs1=1, rs2=2 (`sub x3,x1,x2`) with mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x402081B3; words_written=1 after the write.
- Push I addi x5,x0,-1 then J jal x1,+8 back-to-back → writes 0xFFF00293 at addr 0, then 0x008000EF at addr 4, on consecutive cycles.
- Hold mem_ready=0 and push 5 bundles (depth 4) → in_ready=0 after 4 accepts. Release mem_ready → 4 writes at addrs 0,4,8,12, then the 5th at 16.
- Push fmt=111 → no mem_we, err=1 and stays set. Assert clear → err=0, mem_addr=BASE_ADDR, words_written=0.
- With `INSTR_ENCODER_CHECK_EN`: B-type imm=3 → dropped, err=1. Without it: the word is written with imm[0] discarded.
- Assert rst_n=0 while FIFO holds 3 words and mem_ready=0 → mem_we=0 immediately. After release, no stale writes occur.
